// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a req/ack data bus for RV32I loads/stores,
// handles byte-lane alignment, store masks, load extension and pipeline stall.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_ALUout,
    input  logic [31:0]       in_busB,
    input  logic [2:0]        in_MemOp,
    input  logic [4:0]        in_rd,
    input  logic              in_MemtoReg,
    input  logic              in_RegWr,
    input  logic              in_MemWr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       out_wbdata,
    output logic [4:0]        out_rd,
    output logic              out_RegWr,
    output logic              stall,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [31:0]       r_ldata;

    logic        w_access;
    logic        w_is_load;
    logic        w_illegal;
    logic        w_unal;
    logic        w_bad;
    logic        w_go;
    logic        w_stall;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;
    logic [31:0] w_shift;
    logic [31:0] w_ldext;

    // A store overrides a simultaneous load flag
    assign w_access  = in_MemWr | in_MemtoReg;
    assign w_is_load = in_MemtoReg & ~in_MemWr;

    // Unsigned ops and reserved encodings never reach the bus as stores
    assign w_illegal = (in_MemOp == 3'b011) | (in_MemOp == 3'b110) |
                       (in_MemOp == 3'b111) | (in_MemWr & in_MemOp[2]);
    assign w_unal    = ((in_MemOp == 3'b010) & (in_ALUout[1:0] != 2'b00)) |
                       ((in_MemOp[1:0] == 2'b01) & in_ALUout[0]);
    assign w_bad     = w_access & (w_illegal | w_unal);
    assign w_go      = w_access & ~w_bad;

    // Store data replication and byte enables
    always_comb begin
        w_wdata = in_busB;
        w_wmask = 4'b1111;
        case (in_MemOp[1:0])
            2'b00: begin
                w_wdata = {4{in_busB[7:0]}};
                w_wmask = 4'b0001 << in_ALUout[1:0];
            end
            2'b01: begin
                w_wdata = {2{in_busB[15:0]}};
                w_wmask = 4'b0011 << in_ALUout[1:0];
            end
            default: begin
                w_wdata = in_busB;
                w_wmask = 4'b1111;
            end
        endcase
    end

    assign w_shift = mem_rdata >> {in_ALUout[1:0], 3'b000};

    // Load lane extraction with sign or zero extension
    always_comb begin
        w_ldext = mem_rdata;
        case (in_MemOp)
            3'b000:  w_ldext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ldext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ldext = {24'h0, w_shift[7:0]};
            3'b101:  w_ldext = {16'h0, w_shift[15:0]};
            default: w_ldext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and stall; DONE always returns to IDLE so nothing re-issues
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next  = S_REQ;
                    w_stall = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_ack) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus request launch, completion and load-data capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_wmask <= 4'h0;
            r_ldata <= 32'h0;
        end else if (r_state == S_IDLE && w_go) begin
            r_req   <= 1'b1;
            r_we    <= in_MemWr;
            r_addr  <= {in_ALUout[ADDR_W-1:2], 2'b00};
            r_wdata <= in_MemWr ? w_wdata : 32'h0;
            r_wmask <= in_MemWr ? w_wmask : 4'h0;
        end else if (r_state == S_REQ && mem_ack) begin
            r_req <= 1'b0;
            if (w_is_load) r_ldata <= w_ldext;
        end
    end

    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wmask  = r_wmask;

    assign out_wbdata = (r_state == S_DONE && w_is_load) ? r_ldata : in_ALUout;
    assign out_rd     = in_rd;
    assign out_RegWr  = reset & in_RegWr & ~w_bad;
    assign stall      = reset & w_stall;
    assign misalign   = w_bad;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs (ALU result, store data, MemOp, rd, MemtoReg, RegWr, MemWr).
- Runs load/store transactions on a req/ack data-memory bus, with RV32I byte-lane alignment, store masking and load sign/zero extension.
- Drives the writeback value, rd and RegWr toward MEM/WB, and a stall that freezes the upstream pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, width of byte address on the memory bus.

Ports:
- clock  in  1  system clock; this block updates state on the rising edge. Pipe registers latch on the falling edge, so in_* are stable at every rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_ALUout  in  32  effective byte address for loads/stores; writeback value otherwise.
- in_busB  in  32  store data, right-aligned.
- in_MemOp  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- in_rd  in  5  destination register.
- in_MemtoReg  in  1  instruction is a load.
- in_RegWr  in  1  instruction writes rd.
- in_MemWr  in  1  instruction is a store.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte enables; 0000 on reads.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- mem_ack  in  1  completes the current request; ignored while mem_req=0.
- out_wbdata  out  32  loaded value for loads; in_ALUout otherwise.
- out_rd  out  5  in_rd passthrough.
- out_RegWr  out  1  in_RegWr, forced 0 on misaligned or illegal access.
- stall  out  1  upstream must hold in_* while 1.
- misalign  out  1  current access is misaligned or has an illegal MemOp; no bus cycle is issued.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset asserted forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, load-data register=0. While reset is low, stall=0 and out_RegWr=0.
- Access definition: access = in_MemWr | in_MemtoReg. If both are set, the store wins and no load is performed; out_wbdata = in_ALUout.
- Misalign/illegal conditions:
  - w with addr[1:0] != 0.
  - h or hu (load), or h (store), with addr[0] = 1.
  - MemOp 011, 110, 111, or 100/101 on a store.
  - Effect: misalign=1, stall=0, out_RegWr=0, FSM stays in IDLE. The instruction retires with no bus activity.
- IDLE, legal access present:
  - stall=1 combinationally.
  - At the rising edge, register mem_addr={addr[31:2],2'b00}, mem_we, mem_wdata and mem_wmask; set mem_req=1; go to REQ.
- REQ:
  - stall=1; mem_req and all bus outputs held stable.
  - At a rising edge with mem_ack=1: latch the extended mem_rdata (loads only), drop mem_req, go to DONE.
  - No timeout; mem_req stays high indefinitely until ack.
- DONE:
  - stall=0; out_wbdata presents the latched load value.
  - Next rising edge: unconditionally return to IDLE. The instruction is not re-issued even if in_* are unchanged.
- Latency: zero-wait memory (ack in the first REQ cycle) gives stall high for exactly 2 cycles; each extra wait cycle adds 1.
- Store lanes:
  - sb: wdata={4{busB[7:0]}}, wmask=0001<<addr[1:0].
  - sh: wdata={2{busB[15:0]}}, wmask=0011<<addr[1:0].
  - sw: wdata=busB, wmask=1111.
- Load extract:
  - Byte = rdata>>(8*addr[1:0]), bits [7:0].
  - Half = rdata>>(8*addr[1:0]), bits [15:0].
  - b/h sign-extend; bu/hu zero-extend; w unchanged.
- Non-access instructions (bubbles, ALU ops) pass combinationally: stall=0, out_wbdata=in_ALUout.
- Reset mid-REQ: mem_req drops asynchronously; the memory must abort the transaction. After release, the FSM restarts in IDLE.
- A stray mem_ack while in IDLE or DONE is ignored.

Test Plan:
- Load word, zero-wait: lw with ALUout=0x100, rdata=0xDEADBEEF, ack in the first REQ cycle → mem_addr=0x100, mem_wmask=0000, stall high 2 cycles, out_wbdata=0xDEADBEEF, out_RegWr=1.
- Store byte, 3 wait cycles: sb with ALUout=0x203, busB=0x12345678, ack after 3 wait cycles → mem_addr=0x200, wmask=1000, wdata=0x78787878, stall high 5 cycles.
- Sign/zero extension: rdata=0x80F0FF7F at addr 0x11 → lb gives 0xFFFFFFFF, lbu gives 0x000000FF; lh at 0x12 gives 0xFFFF80F0, lhu gives 0x000080F0.
- Misaligned load: lw at 0x102 → misalign=1, mem_req stays 0, stall=0, out_RegWr=0; same result for sh at 0x101 and MemOp=011.
- Bubble and passthrough: MemtoReg=0, MemWr=0, ALUout=0x55, RegWr=1, rd=7 → stall=0, out_wbdata=0x55, out_rd=7, no mem_req; MemWr=1 with MemtoReg=1 performs the store only.
- Reset mid-operation: reset pulled low during REQ with mem_req=1 → mem_req=0 immediately. After release, a new lw at 0x0 completes normally, and a stray ack seen in IDLE has no effect.
